// File: rtl/load_store_unit.sv
// load_store_unit
// Sequential load/store engine fed by the address generator. Accepts one
// LOAD/STORE per start handshake, issues word-aligned data-memory requests
// with byte masks, extends load data and reports done / access_error /
// bus_error as one-cycle pulses.
//
// Optional feature: define MISALIGNED_SPLIT_EN to split accesses that cross
// a word boundary into two aligned bus requests. Without it such accesses
// are rejected with access_error and the second-request logic is absent.
//
// Ports:
//   clk, reset (async, active low)
//   start/ready                      operation handshake
//   opcode, funct3, address,
//   store_data                       operation captured while ready
//   mem_req/we/addr/mask/wdata       data-memory request, held until mem_ack
//   mem_ack, mem_rdata               data-memory response
//   done, load_data                  completion pulse, extended load result
//   access_error, bus_error          error pulses (mutually exclusive with done)
module load_store_unit #(
    parameter int ACK_TIMEOUT = 255  // max cycles per request without mem_ack, 0 = never
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic [31:0] load_data,
    output logic        access_error,
    output logic        bus_error
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int CW = $clog2(ACK_TIMEOUT + 2);
    localparam logic [CW-1:0] CNT_LAST = (ACK_TIMEOUT == 0) ? '0 : CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ0, REQ1, RESP} state_t;

    state_t          state, nstate;
    logic            is_load_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [29:0]     aw_q;
    logic [3:0]      mask0_q;
    logic [31:0]     wdata0_q;
    logic [CW-1:0]   cnt_q;
    logic            err_acc_q, err_bus_q;
`ifdef MISALIGNED_SPLIT_EN
    logic [3:0]      mask1_q;
    logic [31:0]     wdata1_q;
    logic [31:0]     rlo_q;
    logic [31:0]     word_lo;
    logic [63:0]     wdata_in;
`else
    logic [31:0]     wdata_in;
`endif

    logic [3:0]  base;
    logic [7:0]  mask_in;
    logic        legal_in, reject_in;
    logic [31:0] shifted, ext;
    logic        timeout;

    // Decode of the operation presented at the handshake.
    always_comb begin
        case (funct3[1:0])
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        // Low nibble = first word, high nibble = spill into the next word.
        mask_in = {4'b0000, base} << address[1:0];
`ifdef MISALIGNED_SPLIT_EN
        wdata_in = {32'b0, store_data} << {address[1:0], 3'b000};
`else
        wdata_in = store_data << {address[1:0], 3'b000};
`endif
        case (opcode)
            OP_LOAD:  legal_in = (funct3[1:0] != 2'b11) && (funct3 != 3'b110);
            OP_STORE: legal_in = !funct3[2] && (funct3[1:0] != 2'b11);
            default:  legal_in = 1'b0;
        endcase
`ifdef MISALIGNED_SPLIT_EN
        reject_in = !legal_in;
`else
        reject_in = !legal_in || (mask_in[7:4] != 4'b0000);
`endif
    end

    // Load result: assemble both words, shift the addressed bytes down, extend.
    always_comb begin
`ifdef MISALIGNED_SPLIT_EN
        word_lo = (state == REQ1) ? rlo_q : mem_rdata;
        shifted = 32'({mem_rdata, word_lo} >> {off_q, 3'b000});
`else
        shifted = mem_rdata >> {off_q, 3'b000};
`endif
        case (f3_q[1:0])
            2'b00:   ext = f3_q[2] ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ext = f3_q[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign timeout = (ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    // FSM: next state
    always_comb begin
        nstate = state;
        case (state)
            IDLE: if (start) nstate = reject_in ? RESP : REQ0;
            REQ0: begin
                if (mem_ack) begin
`ifdef MISALIGNED_SPLIT_EN
                    nstate = (mask1_q != 4'b0000) ? REQ1 : RESP;
`else
                    nstate = RESP;
`endif
                end else if (timeout) begin
                    nstate = RESP;
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            REQ1: if (mem_ack || timeout) nstate = RESP;
`endif
            default: nstate = IDLE;
        endcase
    end

    // FSM: outputs. Request outputs are pure functions of the state so an
    // asynchronous reset drops mem_req immediately.
    always_comb begin
        ready     = (state == IDLE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'b0;
        mem_mask  = 4'b0;
        mem_wdata = 32'b0;
        case (state)
            REQ0: begin
                mem_req   = 1'b1;
                mem_we    = !is_load_q;
                mem_addr  = {aw_q, 2'b00};
                mem_mask  = mask0_q;
                mem_wdata = wdata0_q;
            end
`ifdef MISALIGNED_SPLIT_EN
            REQ1: begin
                mem_req   = 1'b1;
                mem_we    = !is_load_q;
                mem_addr  = {aw_q + 30'd1, 2'b00};  // wraps modulo 2^32
                mem_mask  = mask1_q;
                mem_wdata = wdata1_q;
            end
`endif
            default: ;
        endcase
        done         = (state == RESP) && !err_acc_q && !err_bus_q;
        access_error = (state == RESP) && err_acc_q;
        bus_error    = (state == RESP) && err_bus_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_load_q <= 1'b0;
            f3_q      <= 3'b0;
            off_q     <= 2'b0;
            aw_q      <= 30'b0;
            mask0_q   <= 4'b0;
            wdata0_q  <= 32'b0;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            err_bus_q <= 1'b0;
            load_data <= 32'b0;
`ifdef MISALIGNED_SPLIT_EN
            mask1_q   <= 4'b0;
            wdata1_q  <= 32'b0;
            rlo_q     <= 32'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        is_load_q <= (opcode == OP_LOAD);
                        f3_q      <= funct3;
                        off_q     <= address[1:0];
                        aw_q      <= address[31:2];
                        mask0_q   <= mask_in[3:0];
                        wdata0_q  <= wdata_in[31:0];
`ifdef MISALIGNED_SPLIT_EN
                        mask1_q   <= mask_in[7:4];
                        wdata1_q  <= wdata_in[63:32];
`endif
                        err_acc_q <= reject_in;
                        err_bus_q <= 1'b0;
                    end
                end
                REQ0, REQ1: begin
                    if (mem_ack) begin
                        cnt_q <= '0;  // fresh budget for the second request
`ifdef MISALIGNED_SPLIT_EN
                        rlo_q <= mem_rdata;
`endif
                        if (is_load_q && nstate == RESP) load_data <= ext;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (timeout) err_bus_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int TO = 8;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [2:0] K_DONE = 3'b100, K_ACC = 3'b010, K_BUS = 3'b001;

    logic        clk = 0, reset = 0, start = 0;
    logic [6:0]  opcode = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] address = 0, store_data = 0;
    logic        mem_ack = 0;
    logic [31:0] mem_rdata = 0;
    logic        ready, mem_req, mem_we, done, access_error, bus_error;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_mask;

    always #5 clk = ~clk;

    load_store_unit #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready),
        .opcode(opcode), .funct3(funct3), .address(address), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_mask(mem_mask),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .done(done), .load_data(load_data), .access_error(access_error), .bus_error(bus_error)
    );

    typedef struct { logic [31:0] addr; logic [3:0] mask; logic we; logic [31:0] wdata; } req_t;
    typedef struct { logic [2:0] kind; logic [31:0] data; int lat; } cmp_t;

    req_t req_q[$];
    cmp_t cmp_q[$];
    int errors = 0, checks = 0;
    int cyc = 0, acc_cyc = 0;
    int ack_delay = 0;
    bit ack_en = 1;
    logic [31:0] rdata_val = 0;
    logic [31:0] ld_model = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Bus responder and request monitor
    bit   in_req = 0;
    int   wcnt = 0;
    req_t cur, er;
    always @(negedge clk) begin
        mem_ack = 0;
        if (mem_req) begin
            if (!in_req) begin
                in_req = 1;
                wcnt = 0;
                cur = '{mem_addr, mem_mask, mem_we, mem_wdata};
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got addr %h mask %b, none expected", mem_addr, mem_mask);
                end else begin
                    er = req_q.pop_front();
                    chk("req_addr", mem_addr, er.addr);
                    chk("req_mask", 32'(mem_mask), 32'(er.mask));
                    chk("req_we", 32'(mem_we), 32'(er.we));
                    if (er.we) chk("req_wdata", mem_wdata, er.wdata);
                end
            end else begin
                checks++;
                if (mem_addr !== cur.addr || mem_mask !== cur.mask || mem_we !== cur.we || mem_wdata !== cur.wdata) begin
                    errors++;
                    $display("FAIL req_stable: got addr %h mask %b expected addr %h mask %b",
                             mem_addr, mem_mask, cur.addr, cur.mask);
                end
            end
            if (ack_en && wcnt == ack_delay) begin
                mem_ack = 1;
                mem_rdata = rdata_val;
                in_req = 0;
            end
            wcnt++;
        end else begin
            in_req = 0;
        end
    end

    // Completion monitor
    bit   was_pulse = 0;
    cmp_t ce;
    always @(negedge clk) begin
        if (was_pulse) begin
            chk("ready_after_pulse", 32'(ready), 32'd1);
            was_pulse = 0;
        end
        if (reset && (done || access_error || bus_error)) begin
            was_pulse = 1;
            chk("idle_outputs_in_resp", {30'b0, ready, mem_req}, 32'd0);
            if (cmp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pulse: got done=%b acc=%b bus=%b, none expected", done, access_error, bus_error);
            end else begin
                ce = cmp_q.pop_front();
                chk("pulse_kind", {29'b0, done, access_error, bus_error}, {29'b0, ce.kind});
                chk("load_data", load_data, ce.data);
                chk("latency", 32'(cyc - acc_cyc + 1), 32'(ce.lat));
            end
        end
    end

    task automatic exp_req(input logic [31:0] a, input logic [3:0] m, input logic we, input logic [31:0] wd);
        req_q.push_back('{a, m, we, wd});
    endtask

    task automatic exp_cmp(input logic [2:0] k, input int lat);
        cmp_q.push_back('{k, ld_model, lat});
    endtask

    task automatic op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] sd, input bit poke);
        int n;
        @(negedge clk);
        chk("ready_at_start", 32'(ready), 32'd1);
        opcode = opc; funct3 = f3; address = a; store_data = sd; start = 1;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        start = 0;
        if (poke) begin
            // start while busy must be ignored
            opcode = ST; funct3 = 3'b010; address = 32'h900; start = 1;
            @(negedge clk);
            start = 0;
        end
        n = 0;
        while (cmp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (cmp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL wait_timeout: got no pulse within 60 cycles, expected %0d pending", cmp_q.size());
            cmp_q.delete();
        end
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        req_q.delete();
        @(negedge clk);
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] rd, input logic [31:0] val);
        exp_req({a[31:2], 2'b00}, m, 1'b0, 32'h0);
        rdata_val = rd;
        ld_model = val;
        exp_cmp(K_DONE, 2 + ack_delay);
        op(LD, f3, a, 32'h0, 0);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                         input logic [3:0] m, input logic [31:0] wd);
        exp_req({a[31:2], 2'b00}, m, 1'b1, wd);
        exp_cmp(K_DONE, 2 + ack_delay);
        op(ST, f3, a, sd, 0);
    endtask

    task automatic bad(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a);
        exp_cmp(K_ACC, 1);
        op(opc, f3, a, 32'h5555AAAA, 0);
    endtask

    initial begin
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_mask", 32'(mem_mask), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_pulses", {29'b0, done, access_error, bus_error}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        @(negedge clk);
        reset = 1;

        // store then load, immediate ack
        store(3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        load(3'b010, 32'h100, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF);

        // byte/half extension
        load(3'b000, 32'h203, 4'b1000, 32'h80FF7F01, 32'hFFFFFF80);
        load(3'b100, 32'h203, 4'b1000, 32'h80FF7F01, 32'h00000080);
        load(3'b001, 32'h202, 4'b1100, 32'h80FF7F01, 32'hFFFF80FF);
        load(3'b101, 32'h202, 4'b1100, 32'h80FF7F01, 32'h000080FF);
        load(3'b000, 32'h200, 4'b0001, 32'h80FF7F01, 32'h00000001);
        load(3'b001, 32'h201, 4'b0110, 32'h80FF7F01, 32'hFFFFFF7F);
        load(3'b000, 32'h202, 4'b0100, 32'h80FF7F01, 32'hFFFFFFFF);

        // sub-word stores; load_data must hold
        store(3'b000, 32'h301, 32'h123456AB, 4'b0010, 32'h3456AB00);
        store(3'b001, 32'h302, 32'h123456AB, 4'b1100, 32'h56AB0000);

        // wait states, with a start pulse while busy
        ack_delay = 5;
        exp_req(32'h400, 4'b1111, 1'b0, 32'h0);
        rdata_val = 32'h12345678;
        ld_model = 32'h12345678;
        exp_cmp(K_DONE, 7);
        op(LD, 3'b010, 32'h400, 32'h0, 1);
        ack_delay = 0;

        // illegal operations
        bad(7'h33, 3'b000, 32'h100);
        bad(ST, 3'b100, 32'h100);
        bad(LD, 3'b011, 32'h100);
        bad(LD, 3'b110, 32'h100);

`ifdef MISALIGNED_SPLIT_EN
        exp_req(32'h0FFFFFFC, 4'b1100, 1'b1, 32'h33440000);
        exp_req(32'h10000000, 4'b0011, 1'b1, 32'h00001122);
        exp_cmp(K_DONE, 3);
        op(ST, 3'b010, 32'h0FFFFFFE, 32'h11223344, 0);
        exp_req(32'hFFFFFFFC, 4'b1100, 1'b1, 32'h33440000);
        exp_req(32'h00000000, 4'b0011, 1'b1, 32'h00001122);
        exp_cmp(K_DONE, 3);
        op(ST, 3'b010, 32'hFFFFFFFE, 32'h11223344, 0);
        exp_req(32'hFFFFFFFC, 4'b1100, 1'b0, 32'h0);
        exp_req(32'h00000000, 4'b0011, 1'b0, 32'h0);
        rdata_val = 32'h80FF7F01;
        ld_model = 32'h7F0180FF;
        exp_cmp(K_DONE, 3);
        op(LD, 3'b010, 32'hFFFFFFFE, 32'h0, 0);
`else
        bad(LD, 3'b010, 32'h101);
        bad(ST, 3'b001, 32'h103);
        bad(ST, 3'b010, 32'h102);
`endif

        // ack timeout
        ack_en = 0;
        exp_req(32'h500, 4'b1111, 1'b0, 32'h0);
        exp_cmp(K_BUS, TO + 1);
        op(LD, 3'b010, 32'h500, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("req_low_after_timeout", 32'(mem_req), 32'd0);
            @(negedge clk);
        end

        // reset while in REQ0
        exp_req(32'h600, 4'b1111, 1'b0, 32'h0);
        @(negedge clk);
        opcode = LD; funct3 = 3'b010; address = 32'h600; start = 1;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        start = 0;
        #2 chk("req_before_reset", 32'(mem_req), 32'd1);
        reset = 0;
        #1 chk("req_async_drop", 32'(mem_req), 32'd0);
        chk("ready_in_reset", 32'(ready), 32'd1);
        repeat (2) @(negedge clk);
        #1 reset = 1;
        ld_model = 0;
        chk("load_data_after_reset", load_data, 32'd0);
        chk("req_q_after_reset", 32'(req_q.size()), 32'd0);
        ack_en = 1;
        load(3'b010, 32'h700, 4'b1111, 32'hCAFEF00D, 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        chk("cmp_q_final", 32'(cmp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
